// File: rtl/getir2.sv
// getir2 - second fetch stage.
// Queues PCs from fetch stage 1, counts outstanding L1B requests, pairs each
// in-order L1B response with its PC and hands the pair to decode through a
// registered valid/ready output. A redirect flushes queued state and marks
// every older in-flight response to be dropped on arrival.
// Optional build macro GETIR2_HIZALAMA_HATA_EN: flags misaligned PCs and
// replaces their instruction with a NOP.
module getir2 #(
  parameter int PS_BIT        = 32,
  parameter int BUYRUK_BIT    = 32,
  parameter int FIFO_DERINLIK = 2,
  parameter int MAX_BEKLEYEN  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  g1_istek_yapildi_i,
  input  logic [PS_BIT-1:0]     g1_ps_i,
  input  logic                  g1_ps_gecerli_i,
  output logic                  g1_ps_hazir_o,
  input  logic [BUYRUK_BIT-1:0] l1b_yanit_buyruk_i,
  input  logic                  l1b_yanit_gecerli_i,
  output logic                  l1b_yanit_hazir_o,
  input  logic                  cek_ps_gecerli_i,
  output logic [PS_BIT-1:0]     coz_ps_o,
  output logic [BUYRUK_BIT-1:0] coz_buyruk_o,
  output logic                  coz_gecerli_o,
  input  logic                  coz_hazir_i,
  output logic                  coz_hizalama_hata_o
);

  localparam int PTR_BIT   = $clog2(FIFO_DERINLIK);
  localparam int SAY_BIT   = $clog2(FIFO_DERINLIK + 1);
  localparam int SAYAC_BIT = $clog2(MAX_BEKLEYEN + 1);
  localparam logic [SAY_BIT-1:0]   DOLU      = SAY_BIT'(FIFO_DERINLIK);
  localparam logic [SAYAC_BIT-1:0] SAYAC_MAX = SAYAC_BIT'(MAX_BEKLEYEN);

  // PC FIFO storage
  logic [PS_BIT-1:0]  ps_mem [FIFO_DERINLIK];
  logic [PTR_BIT-1:0] ps_yaz, ps_oku;
  logic [SAY_BIT-1:0] ps_say;

  // Instruction FIFO storage
  logic [BUYRUK_BIT-1:0] buy_mem [FIFO_DERINLIK];
  logic [PTR_BIT-1:0]    buy_yaz, buy_oku;
  logic [SAY_BIT-1:0]    buy_say;

  // Outstanding request counter and count of stale responses still to drop
  logic [SAYAC_BIT-1:0] bekleyen, bekleyen_ns;
  logic [SAYAC_BIT-1:0] atilacak, atilacak_ns;

  logic                  ps_dolu, ps_bos, buy_dolu, buy_bos;
  logic                  ps_it, ps_cek, buy_it, buy_cek;
  logic                  yanit_hs, yanit_kabul;
  logic                  buy_bas_gecerli, cikis_yukle;
  logic [PS_BIT-1:0]     ps_bas;
  logic [BUYRUK_BIT-1:0] buy_bas;
  logic [BUYRUK_BIT-1:0] cikis_buyruk;

  assign ps_dolu  = (ps_say == DOLU);
  assign ps_bos   = (ps_say == '0);
  assign buy_dolu = (buy_say == DOLU);
  assign buy_bos  = (buy_say == '0);

  // Ready signals depend only on registered state, so a same-cycle pop never frees a slot
  assign g1_ps_hazir_o     = !rst_i && !ps_dolu;
  assign l1b_yanit_hazir_o = !rst_i && ((atilacak != '0) || !buy_dolu);

  assign yanit_hs    = l1b_yanit_gecerli_i && l1b_yanit_hazir_o;
  assign yanit_kabul = yanit_hs && (atilacak == '0) && !cek_ps_gecerli_i;
  assign ps_it       = g1_ps_gecerli_i && g1_ps_hazir_o && !cek_ps_gecerli_i;

  // An accepted response may bypass an empty instruction FIFO straight into the output register
  assign ps_bas          = ps_mem[ps_oku];
  assign buy_bas_gecerli = !buy_bos || yanit_kabul;
  assign buy_bas         = buy_bos ? l1b_yanit_buyruk_i : buy_mem[buy_oku];

  assign cikis_yukle = !cek_ps_gecerli_i && !ps_bos && buy_bas_gecerli &&
                       (!coz_gecerli_o || coz_hazir_i);
  assign ps_cek      = cikis_yukle;
  assign buy_cek     = cikis_yukle && !buy_bos;
  assign buy_it      = yanit_kabul && !(cikis_yukle && buy_bos);

  // Next values of the outstanding and drop counters, saturating at both ends
  always_comb begin
    atilacak_ns = atilacak;
    bekleyen_ns = bekleyen;
    if (cek_ps_gecerli_i) begin
      atilacak_ns = (yanit_hs && bekleyen != '0) ? bekleyen - 1'b1 : bekleyen;
      bekleyen_ns = (g1_istek_yapildi_i && atilacak_ns != SAYAC_MAX) ?
                    atilacak_ns + 1'b1 : atilacak_ns;
    end else begin
      if (yanit_hs && atilacak != '0)
        atilacak_ns = atilacak - 1'b1;
      if (g1_istek_yapildi_i && !yanit_hs && bekleyen != SAYAC_MAX)
        bekleyen_ns = bekleyen + 1'b1;
      else if (!g1_istek_yapildi_i && yanit_hs && bekleyen != '0)
        bekleyen_ns = bekleyen - 1'b1;
    end
  end

  // Counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bekleyen <= '0;
      atilacak <= '0;
    end else begin
      bekleyen <= bekleyen_ns;
      atilacak <= atilacak_ns;
    end
  end

  // PC FIFO: pointers wrap naturally, separate count gives full/empty
  always_ff @(posedge clk_i) begin
    if (rst_i || cek_ps_gecerli_i) begin
      ps_yaz <= '0;
      ps_oku <= '0;
      ps_say <= '0;
    end else begin
      if (ps_it) begin
        ps_mem[ps_yaz] <= g1_ps_i;
        ps_yaz         <= ps_yaz + 1'b1;
      end
      if (ps_cek)
        ps_oku <= ps_oku + 1'b1;
      if (ps_it && !ps_cek)
        ps_say <= ps_say + 1'b1;
      else if (!ps_it && ps_cek)
        ps_say <= ps_say - 1'b1;
    end
  end

  // Instruction FIFO, same organisation as the PC FIFO
  always_ff @(posedge clk_i) begin
    if (rst_i || cek_ps_gecerli_i) begin
      buy_yaz <= '0;
      buy_oku <= '0;
      buy_say <= '0;
    end else begin
      if (buy_it) begin
        buy_mem[buy_yaz] <= l1b_yanit_buyruk_i;
        buy_yaz          <= buy_yaz + 1'b1;
      end
      if (buy_cek)
        buy_oku <= buy_oku + 1'b1;
      if (buy_it && !buy_cek)
        buy_say <= buy_say + 1'b1;
      else if (!buy_it && buy_cek)
        buy_say <= buy_say - 1'b1;
    end
  end

`ifdef GETIR2_HIZALAMA_HATA_EN
  localparam logic [BUYRUK_BIT-1:0] NOP = BUYRUK_BIT'(32'h0000_0013);
  logic cikis_hata;

  assign cikis_hata   = (ps_bas[1:0] != 2'b00);
  assign cikis_buyruk = cikis_hata ? NOP : buy_bas;

  // Misalignment flag travels with the output pair
  always_ff @(posedge clk_i) begin
    if (rst_i)
      coz_hizalama_hata_o <= 1'b0;
    else if (!cek_ps_gecerli_i && cikis_yukle)
      coz_hizalama_hata_o <= cikis_hata;
  end
`else
  assign cikis_buyruk        = buy_bas;
  assign coz_hizalama_hata_o = 1'b0;
`endif

  // Output register toward decode; holds while stalled, flush only drops valid
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      coz_gecerli_o <= 1'b0;
      coz_ps_o      <= '0;
      coz_buyruk_o  <= '0;
    end else if (cek_ps_gecerli_i) begin
      coz_gecerli_o <= 1'b0;
    end else if (cikis_yukle) begin
      coz_gecerli_o <= 1'b1;
      coz_ps_o      <= ps_bas;
      coz_buyruk_o  <= cikis_buyruk;
    end else if (coz_hazir_i) begin
      coz_gecerli_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_getir2.sv
// tb_getir2 - directed scoreboard bench for getir2.
// Stimulus pushes hand-computed expected pairs into a queue; a monitor pops
// and compares on every decode handshake. Honors GETIR2_HIZALAMA_HATA_EN.
module tb_getir2;

  logic        clk = 1'b0;
  logic        rst;
  logic        istek;
  logic [31:0] g1Ps;
  logic        g1PsGecerli;
  logic        g1PsHazir;
  logic [31:0] yanitBuyruk;
  logic        yanitGecerli;
  logic        yanitHazir;
  logic        cek;
  logic [31:0] cozPs;
  logic [31:0] cozBuyruk;
  logic        cozGecerli;
  logic        cozHazir;
  logic        cozHata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] ps;
    logic [31:0] buyruk;
    logic        hata;
  } beklenen_t;

  beklenen_t sb[$];

  getir2 dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .g1_istek_yapildi_i  (istek),
    .g1_ps_i             (g1Ps),
    .g1_ps_gecerli_i     (g1PsGecerli),
    .g1_ps_hazir_o       (g1PsHazir),
    .l1b_yanit_buyruk_i  (yanitBuyruk),
    .l1b_yanit_gecerli_i (yanitGecerli),
    .l1b_yanit_hazir_o   (yanitHazir),
    .cek_ps_gecerli_i    (cek),
    .coz_ps_o            (cozPs),
    .coz_buyruk_o        (cozBuyruk),
    .coz_gecerli_o       (cozGecerli),
    .coz_hazir_i         (cozHazir),
    .coz_hizalama_hata_o (cozHata)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string ad, input logic [31:0] gercek,
                             input logic [31:0] beklenen);
    checks++;
    if (gercek !== beklenen) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", ad, gercek, beklenen);
    end
  endtask

  task automatic applyStimulus(input logic ist, input logic psv, input logic [31:0] ps,
                               input logic yv, input logic [31:0] yb, input logic c);
    istek        = ist;
    g1PsGecerli  = psv;
    g1Ps         = ps;
    yanitGecerli = yv;
    yanitBuyruk  = yb;
    cek          = c;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic expectPair(input logic [31:0] ps, input logic [31:0] buy, input logic h);
    beklenen_t e;
    e.ps = ps;
    e.buyruk = buy;
    e.hata = h;
    sb.push_back(e);
  endtask

  task automatic midCycle();
    @(negedge clk);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      idle();
      nextCycle();
    end
  endtask

  // Monitor: every decode handshake must match the oldest expected pair
  always @(negedge clk) begin : monitor
    beklenen_t e;
    if (cozGecerli === 1'b1 && cozHazir === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pair: actual ps=0x%08h buyruk=0x%08h required none",
                 cozPs, cozBuyruk);
      end else begin
        e = sb.pop_front();
        checkOutput("pair_ps", cozPs, e.ps);
        checkOutput("pair_buyruk", cozBuyruk, e.buyruk);
        checkOutput("pair_hata", {31'b0, cozHata}, {31'b0, e.hata});
      end
    end
  end

  initial begin
    rst      = 1'b1;
    cozHazir = 1'b1;
    idle();
    nextCycle();
    nextCycle();
    midCycle();
    checkOutput("rst_gecerli", {31'b0, cozGecerli}, 32'h0);
    checkOutput("rst_ps", cozPs, 32'h0);
    checkOutput("rst_buyruk", cozBuyruk, 32'h0);
    checkOutput("rst_hata", {31'b0, cozHata}, 32'h0);
    checkOutput("rst_ps_hazir", {31'b0, g1PsHazir}, 32'h0);
    checkOutput("rst_yanit_hazir", {31'b0, yanitHazir}, 32'h0);
    nextCycle();
    rst = 1'b0;

    // Single request: PC, then response two cycles later, valid one cycle after that
    applyStimulus(1'b1, 1'b1, 32'h4000_0000, 1'b0, 32'h0, 1'b0);
    midCycle();
    checkOutput("t1_ps_hazir", {31'b0, g1PsHazir}, 32'h1);
    nextCycle();
    idleCycles(1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h0050_0093, 1'b0);
    expectPair(32'h4000_0000, 32'h0050_0093, 1'b0);
    midCycle();
    checkOutput("t1_gecerli_before", {31'b0, cozGecerli}, 32'h0);
    nextCycle();
    idle();
    midCycle();
    checkOutput("t1_gecerli_latency", {31'b0, cozGecerli}, 32'h1);
    nextCycle();
    midCycle();
    checkOutput("t1_gecerli_drop", {31'b0, cozGecerli}, 32'h0);
    nextCycle();

    // Decode stalled: both FIFOs fill, output holds the first pair
    cozHazir = 1'b0;
    applyStimulus(1'b1, 1'b1, 32'h4000_0000, 1'b0, 32'h0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'h4000_0004, 1'b0, 32'h0, 1'b0);
    nextCycle();
    idle();
    midCycle();
    checkOutput("t2_ps_full", {31'b0, g1PsHazir}, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h1111_1111, 1'b0);
    expectPair(32'h4000_0000, 32'h1111_1111, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'h4000_0008, 1'b1, 32'h2222_2222, 1'b0);
    expectPair(32'h4000_0004, 32'h2222_2222, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h3333_3333, 1'b0);
    expectPair(32'h4000_0008, 32'h3333_3333, 1'b0);
    nextCycle();
    idle();
    midCycle();
    checkOutput("t2_ps_hazir", {31'b0, g1PsHazir}, 32'h0);
    checkOutput("t2_yanit_hazir", {31'b0, yanitHazir}, 32'h0);
    checkOutput("t2_hold_gecerli", {31'b0, cozGecerli}, 32'h1);
    checkOutput("t2_hold_ps", cozPs, 32'h4000_0000);
    checkOutput("t2_hold_buyruk", cozBuyruk, 32'h1111_1111);
    nextCycle();
    cozHazir = 1'b1;
    idleCycles(4);
    midCycle();
    checkOutput("t2_drained", {31'b0, cozGecerli}, 32'h0);
    nextCycle();

    // Flush with two requests outstanding: next two responses are dropped
    applyStimulus(1'b1, 1'b1, 32'h4000_0010, 1'b0, 32'h0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'h4000_0014, 1'b0, 32'h0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'h4000_0100, 1'b0, 32'h0, 1'b0);
    midCycle();
    checkOutput("t3_flush_gecerli", {31'b0, cozGecerli}, 32'h0);
    nextCycle();
    cozHazir = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_0001, 1'b0);
    midCycle();
    checkOutput("t3_drop1_hazir", {31'b0, yanitHazir}, 32'h1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_0002, 1'b0);
    midCycle();
    checkOutput("t3_drop2_hazir", {31'b0, yanitHazir}, 32'h1);
    checkOutput("t3_drop_gecerli", {31'b0, cozGecerli}, 32'h0);
    nextCycle();
    cozHazir = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0113, 1'b0);
    expectPair(32'h4000_0100, 32'h0000_0113, 1'b0);
    nextCycle();
    idleCycles(3);

    // Flush coinciding with a response, a new request and a PC push
    applyStimulus(1'b1, 1'b1, 32'h4000_0020, 1'b0, 32'h0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'h4000_0024, 1'b0, 32'h0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'h4000_BAD0, 1'b1, 32'hBAD0_0001, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 32'h4000_0200, 1'b0, 32'h0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'hBAD0_0002, 1'b0);
    midCycle();
    checkOutput("t4_drop_hazir", {31'b0, yanitHazir}, 32'h1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h00A0_0093, 1'b0);
    expectPair(32'h4000_0200, 32'h00A0_0093, 1'b0);
    nextCycle();
    idleCycles(3);

    // Misaligned PC
    applyStimulus(1'b1, 1'b1, 32'h4000_0002, 1'b0, 32'h0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h0070_0093, 1'b0);
`ifdef GETIR2_HIZALAMA_HATA_EN
    expectPair(32'h4000_0002, 32'h0000_0013, 1'b1);
`else
    expectPair(32'h4000_0002, 32'h0070_0093, 1'b0);
`endif
    nextCycle();
    idleCycles(3);

    // Reset mid-operation discards a queued PC and clears the output
    applyStimulus(1'b1, 1'b1, 32'h4000_0030, 1'b0, 32'h0, 1'b0);
    nextCycle();
    idle();
    rst = 1'b1;
    nextCycle();
    midCycle();
    checkOutput("t6_rst_ps_hazir", {31'b0, g1PsHazir}, 32'h0);
    checkOutput("t6_rst_yanit_hazir", {31'b0, yanitHazir}, 32'h0);
    checkOutput("t6_rst_gecerli", {31'b0, cozGecerli}, 32'h0);
    checkOutput("t6_rst_ps", cozPs, 32'h0);
    checkOutput("t6_rst_buyruk", cozBuyruk, 32'h0);
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 32'h4000_0300, 1'b0, 32'h0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0333, 1'b0);
    expectPair(32'h4000_0300, 32'h0000_0333, 1'b0);
    nextCycle();
    idle();

    // Bounded drain of the scoreboard
    for (int i = 0; i < 20 && sb.size() != 0; i++)
      nextCycle();
    nextCycle();
    checkOutput("scoreboard_drain", sb.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
